// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//   Serial PRBS receiver/checker. Self-synchronises a local copy of the
//   generator LFSR from the received feedback-bit stream, then flags and
//   counts every received bit that deviates from the locally predicted bit.
//
//   Modes: HUNT (fill the local register from the stream), SYNC (confirm
//   SYNC_LEN consecutive correct predictions), LOCK (free-running local LFSR,
//   compare every valid bit).
//
//   Optional feature macro: LOSS_OF_LOCK_EN
//     defined   : LOL_THRESH consecutive locked mismatches return to HUNT.
//     undefined : LOCK is held until rst_n.
//
// Ports
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous active-low reset
//   in_valid  in   1          in_bit is valid this cycle
//   in_bit    in   1          received serial bit
//   clr_cnt   in   1          synchronous clear of err_cnt (wins over increment)
//   locked    out  1          registered: checker in LOCK
//   err       out  1          registered one-cycle pulse: locked mismatch
//   err_cnt   out  ERR_CNT_W  registered saturating locked-mismatch count
// -----------------------------------------------------------------------------
module lfsr_checker #(
    parameter int               WIDTH      = 3,
    parameter logic [WIDTH-1:0] TAPS       = 3'b110,
    parameter int               SYNC_LEN   = 4,
    parameter int               ERR_CNT_W  = 8,
    parameter int               LOL_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {
        HUNT = 2'b00,
        SYNC = 2'b01,
        LOCK = 2'b10
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     shift_r;
    logic [FILL_W-1:0]    fill_r;
    logic [MATCH_W-1:0]   match_r;
`ifdef LOSS_OF_LOCK_EN
    localparam int RUN_W = $clog2(LOL_THRESH + 1);
    logic [RUN_W-1:0]     run_r;
`endif

    logic pred_s;

    // Feedback bit the generator would transmit from a given state.
    function automatic logic lfsr_fb(input logic [WIDTH-1:0] s);
        return ^(s & TAPS);
    endfunction

    // Prediction of the next received bit from the local register.
    always_comb begin
        pred_s = lfsr_fb(shift_r);
    end

    // Mode sequencing, local LFSR, lock/error flags and saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HUNT;
            shift_r <= {WIDTH{1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            match_r <= {MATCH_W{1'b0}};
`ifdef LOSS_OF_LOCK_EN
            run_r   <= {RUN_W{1'b0}};
`endif
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= {ERR_CNT_W{1'b0}};
        end else begin
            err <= 1'b0;
            if (in_valid) begin
                case (state_r)
                    HUNT: begin
                        shift_r <= {shift_r[WIDTH-2:0], in_bit};
                        if (fill_r == FILL_W'(WIDTH - 1)) begin
                            fill_r  <= {FILL_W{1'b0}};
                            match_r <= {MATCH_W{1'b0}};
                            state_r <= SYNC;
                        end else begin
                            fill_r <= fill_r + 1'b1;
                        end
                    end
                    SYNC: begin
                        // Keep reloading from the stream until predictions hold;
                        // an all-zero register is never accepted as evidence.
                        shift_r <= {shift_r[WIDTH-2:0], in_bit};
                        if ((in_bit == pred_s) && (shift_r != {WIDTH{1'b0}})) begin
                            if (match_r == MATCH_W'(SYNC_LEN - 1)) begin
                                match_r <= {MATCH_W{1'b0}};
                                state_r <= LOCK;
                                locked  <= 1'b1;
`ifdef LOSS_OF_LOCK_EN
                                run_r   <= {RUN_W{1'b0}};
`endif
                            end else begin
                                match_r <= match_r + 1'b1;
                            end
                        end else begin
                            match_r <= {MATCH_W{1'b0}};
                        end
                    end
                    LOCK: begin
                        // Free-running: the received bit never enters the
                        // register, so a corrupted bit cannot derail prediction.
                        shift_r <= {shift_r[WIDTH-2:0], pred_s};
                        if (in_bit != pred_s) begin
                            err <= 1'b1;
                            if (err_cnt != {ERR_CNT_W{1'b1}}) begin
                                err_cnt <= err_cnt + 1'b1;
                            end else begin
                                err_cnt <= err_cnt;
                            end
`ifdef LOSS_OF_LOCK_EN
                            if (run_r == RUN_W'(LOL_THRESH - 1)) begin
                                run_r   <= {RUN_W{1'b0}};
                                fill_r  <= {FILL_W{1'b0}};
                                locked  <= 1'b0;
                                state_r <= HUNT;
                            end else begin
                                run_r <= run_r + 1'b1;
                            end
`endif
                        end else begin
`ifdef LOSS_OF_LOCK_EN
                            run_r <= {RUN_W{1'b0}};
`endif
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                        fill_r  <= {FILL_W{1'b0}};
                        locked  <= 1'b0;
                    end
                endcase
            end
            // Clear takes priority over a same-cycle increment.
            if (clr_cnt) begin
                err_cnt <= {ERR_CNT_W{1'b0}};
            end
        end
    end

endmodule
